// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with stall hold, flush, load-use bubble
// insertion and a saturating bubble counter.
//
// Ports:
//   clk, rst          core clock, async active-high reset
//   stall, flush      hold request / kill request for the EX slot
//   id_*              decoded instruction presented by ID
//   ex_*              registered copy presented to EX
//   hazard_stall      load-use stall request to PC and IF/ID
//   bubble_cnt        saturating count of load-use bubbles
module id_ex_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_WIDTH-1:0] id_pc,
  input  logic [DATA_WIDTH-1:0] id_rd1,
  input  logic [DATA_WIDTH-1:0] id_rd2,
  input  logic [DATA_WIDTH-1:0] id_imm,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic [2:0]            id_funct3,
  input  logic [3:0]            id_alu_op,
  input  logic                  id_alu_src,
  input  logic [1:0]            id_wb_sel,
  input  logic                  id_reg_we,
  input  logic                  id_mem_re,
  input  logic                  id_mem_we,
  input  logic                  id_branch,
  input  logic                  id_jump,
  output logic                  ex_valid,
  output logic [DATA_WIDTH-1:0] ex_pc,
  output logic [DATA_WIDTH-1:0] ex_rd1,
  output logic [DATA_WIDTH-1:0] ex_rd2,
  output logic [DATA_WIDTH-1:0] ex_imm,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [4:0]            ex_rd,
  output logic [2:0]            ex_funct3,
  output logic [3:0]            ex_alu_op,
  output logic                  ex_alu_src,
  output logic [1:0]            ex_wb_sel,
  output logic                  ex_reg_we,
  output logic                  ex_mem_re,
  output logic                  ex_mem_we,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  hazard_stall,
  output logic [CNT_WIDTH-1:0]  bubble_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [3:0]            alu_op;
    logic                  alu_src;
    logic [1:0]            wb_sel;
    logic                  reg_we;
    logic                  mem_re;
    logic                  mem_we;
    logic                  branch;
    logic                  jump;
  } id_ex_t;

  id_ex_t               id_pkt;
  id_ex_t               ex_d, ex_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 rd_match;

  assign id_pkt = '{
    valid:   id_valid,
    pc:      id_pc,
    rd1:     id_rd1,
    rd2:     id_rd2,
    imm:     id_imm,
    rs1:     id_rs1,
    rs2:     id_rs2,
    rd:      id_rd,
    funct3:  id_funct3,
    alu_op:  id_alu_op,
    alu_src: id_alu_src,
    wb_sel:  id_wb_sel,
    reg_we:  id_reg_we,
    mem_re:  id_mem_re,
    mem_we:  id_mem_we,
    branch:  id_branch,
    jump:    id_jump
  };

  assign rd_match = (ex_q.rd == id_rs1)
                  | (ex_q.rd == id_rs2);

  // x0 never carries a dependency, so a load to x0 never stalls.
  assign hazard_stall = ex_q.valid
                      & ex_q.mem_re
                      & (ex_q.rd != 5'd0)
                      & id_valid
                      & rd_match;

  // Conditions may overlap (flush with stall), so priority, not unique.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    priority case (1'b1)
      flush: ex_d = '0;
      stall: ex_d = ex_q;
      hazard_stall: begin
        ex_d = '0;
        if (cnt_q != {CNT_WIDTH{1'b1}})
          cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      default: ex_d = id_pkt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_pc      = ex_q.pc;
  assign ex_rd1     = ex_q.rd1;
  assign ex_rd2     = ex_q.rd2;
  assign ex_imm     = ex_q.imm;
  assign ex_rs1     = ex_q.rs1;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_funct3  = ex_q.funct3;
  assign ex_alu_op  = ex_q.alu_op;
  assign ex_alu_src = ex_q.alu_src;
  assign ex_wb_sel  = ex_q.wb_sel;
  assign ex_reg_we  = ex_q.reg_we;
  assign ex_mem_re  = ex_q.mem_re;
  assign ex_mem_we  = ex_q.mem_we;
  assign ex_branch  = ex_q.branch;
  assign ex_jump    = ex_q.jump;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: vector table with a scoreboard queue,
// plus hand-written saturation and async-reset sequences.
module tb_id_ex_pipe;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
  } pkt_t;

  typedef struct {
    logic       stall;
    logic       flush;
    pkt_t       id;
    logic       hz;
    pkt_t       exp;
    logic [3:0] cnt;
  } vec_t;

  typedef struct {
    pkt_t       exp;
    logic [3:0] cnt;
  } sb_t;

  logic clk = 1'b0;
  logic rst;
  logic stall, flush;
  pkt_t id_in, ex_act;
  logic hazard_stall;
  logic [3:0] bubble_cnt;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  id_ex_pipe #(.DATA_WIDTH(32), .CNT_WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_in.valid), .id_pc(id_in.pc),
    .id_rd1(id_in.rd1), .id_rd2(id_in.rd2), .id_imm(id_in.imm),
    .id_rs1(id_in.rs1), .id_rs2(id_in.rs2), .id_rd(id_in.rd),
    .id_funct3(id_in.funct3), .id_alu_op(id_in.alu_op),
    .id_alu_src(id_in.alu_src), .id_wb_sel(id_in.wb_sel),
    .id_reg_we(id_in.reg_we), .id_mem_re(id_in.mem_re),
    .id_mem_we(id_in.mem_we), .id_branch(id_in.branch),
    .id_jump(id_in.jump),
    .ex_valid(ex_act.valid), .ex_pc(ex_act.pc),
    .ex_rd1(ex_act.rd1), .ex_rd2(ex_act.rd2), .ex_imm(ex_act.imm),
    .ex_rs1(ex_act.rs1), .ex_rs2(ex_act.rs2), .ex_rd(ex_act.rd),
    .ex_funct3(ex_act.funct3), .ex_alu_op(ex_act.alu_op),
    .ex_alu_src(ex_act.alu_src), .ex_wb_sel(ex_act.wb_sel),
    .ex_reg_we(ex_act.reg_we), .ex_mem_re(ex_act.mem_re),
    .ex_mem_we(ex_act.mem_we), .ex_branch(ex_act.branch),
    .ex_jump(ex_act.jump),
    .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
  );

  function automatic pkt_t mk(input logic v,
                              input logic [31:0] pc, input logic [31:0] rd1,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd,
                              input logic mre, input logic we);
    pkt_t p;
    p.valid   = v;
    p.pc      = pc;
    p.rd1     = rd1;
    p.rd2     = ~rd1;
    p.imm     = (pc << 2) ^ 32'h0F0F;
    p.rs1     = rs1;
    p.rs2     = rs2;
    p.rd      = rd;
    p.funct3  = pc[4:2];
    p.alu_op  = pc[7:4];
    p.alu_src = pc[3];
    p.wb_sel  = {mre, we};
    p.reg_we  = we;
    p.mem_re  = mre;
    p.mem_we  = pc[8];
    p.branch  = pc[9];
    p.jump    = pc[10];
    return p;
  endfunction

  task automatic add(input logic s, input logic f, input pkt_t id,
                     input logic hz, input pkt_t exp, input logic [3:0] cnt);
    vec_t v;
    v.stall = s; v.flush = f; v.id = id;
    v.hz = hz; v.exp = exp; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one vector, check the combinational hazard, then after the
  // edge pop the scoreboard entry and compare the registered state.
  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    stall = v.stall;
    flush = v.flush;
    id_in = v.id;
    #1;
    chk({tag, " hazard"}, 160'(hazard_stall), 160'(v.hz));
    e.exp = v.exp;
    e.cnt = v.cnt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      tot_cnt++;
      $display("FAIL %s scoreboard: empty queue", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, " ex"}, 160'(ex_act), 160'(e.exp));
      chk({tag, " cnt"}, 160'(bubble_cnt), 160'(e.cnt));
    end
  endtask

  pkt_t z, a, l, d, l0, e1, p, q1, q2, q3, l2, d2, n1, n2, l3, n3;

  initial begin
    z = '0;
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    id_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex", 160'(ex_act), 160'(z));
    chk("reset cnt", 160'(bubble_cnt), 160'(4'd0));
    chk("reset hazard", 160'(hazard_stall), 160'(1'b0));
    rst = 1'b0;

    a  = mk(1, 32'h100, 32'hA5A5A5A5, 1, 2, 5, 0, 1);
    l  = mk(1, 32'h104, 32'h11111111, 4, 6, 3, 1, 1);
    d  = mk(1, 32'h108, 32'h22222222, 7, 3, 8, 0, 1);
    l0 = mk(1, 32'h10C, 32'h33333333, 1, 2, 0, 1, 1);
    e1 = mk(1, 32'h110, 32'h44444444, 0, 9, 4, 0, 1);
    p  = mk(1, 32'h200, 32'h55555555, 1, 2, 6, 0, 1);
    q1 = mk(1, 32'h204, 32'h66666666, 3, 4, 7, 0, 0);
    q2 = mk(1, 32'h7F8, 32'h77777777, 5, 6, 9, 0, 1);
    q3 = mk(1, 32'h60C, 32'h88888888, 7, 8, 13, 0, 1);
    l2 = mk(1, 32'h300, 32'h99999999, 1, 2, 10, 1, 1);
    d2 = mk(1, 32'h304, 32'hAAAAAAAA, 10, 2, 14, 0, 1);
    n1 = mk(0, 32'h400, 32'hBBBBBBBB, 1, 2, 11, 1, 1);
    n2 = mk(1, 32'h404, 32'hCCCCCCCC, 11, 2, 15, 0, 1);
    l3 = mk(1, 32'h500, 32'hDDDDDDDD, 1, 2, 12, 1, 1);
    n3 = mk(0, 32'h504, 32'hEEEEEEEE, 12, 12, 16, 0, 1);

    add(0, 0, a,  0, a,  0);
    add(0, 0, l,  0, l,  0);
    add(0, 0, d,  1, z,  1);
    add(0, 0, d,  0, d,  1);
    add(0, 0, l0, 0, l0, 1);
    add(0, 0, e1, 0, e1, 1);
    add(0, 0, p,  0, p,  1);
    add(1, 0, q1, 0, p,  1);
    add(1, 0, q2, 0, p,  1);
    add(1, 0, q3, 0, p,  1);
    add(0, 0, q3, 0, q3, 1);
    add(0, 0, l2, 0, l2, 1);
    add(1, 1, d2, 1, z,  1);
    add(0, 0, n1, 0, n1, 1);
    add(0, 0, n2, 0, n2, 1);
    add(0, 0, l3, 0, l3, 1);
    add(0, 0, n3, 0, n3, 1);

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    begin
      vec_t v;
      int   exp_cnt = 1;
      for (int i = 0; i < 20; i++) begin
        v.stall = 0; v.flush = 0;
        v.id = l; v.hz = 0; v.exp = l; v.cnt = 4'(exp_cnt);
        apply(v, $sformatf("sat%0d load", i));
        if (exp_cnt < 15) exp_cnt++;
        v.id = d; v.hz = 1; v.exp = z; v.cnt = 4'(exp_cnt);
        apply(v, $sformatf("sat%0d use", i));
      end
      v.id = a; v.hz = 0; v.exp = a; v.cnt = 4'd15;
      apply(v, "pre-reset");
    end

    #3;
    rst = 1'b1;
    #1;
    chk("async valid", 160'(ex_act.valid), 160'(1'b0));
    chk("async reg_we", 160'(ex_act.reg_we), 160'(1'b0));
    chk("async cnt", 160'(bubble_cnt), 160'(4'd0));
    @(negedge clk);
    rst = 1'b0;
    begin
      vec_t v;
      v.stall = 0; v.flush = 0;
      v.id = p; v.hz = 0; v.exp = p; v.cnt = 4'd0;
      apply(v, "post-reset");
    end

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register of the 5-stage RV32I core.
- Sits directly downstream of the decode-stage register file. Captures the two read operands, immediate, PC and decoded control, and presents them to EX one cycle later.
- Adds stall hold, flush, and load-use hazard detection with bubble insertion.
- Keeps a saturating bubble counter for performance analysis.

Parameters:
- DATA_WIDTH, 32, width of operands, immediate and PC.
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold request from a later stage (e.g. memory wait).
- flush  in  1  kill the instruction entering EX (taken branch/jump resolved in EX).
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  DATA_WIDTH  instruction PC.
- id_rd1, id_rd2  in  DATA_WIDTH  register-file read data for rs1/rs2.
- id_imm  in  DATA_WIDTH  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_funct3  in  3  funct3 field.
- id_alu_op  in  4  ALU operation select.
- id_alu_src  in  1  ALU B = imm (1) / rd2 (0).
- id_wb_sel  in  2  writeback source select.
- id_reg_we, id_mem_re, id_mem_we, id_branch, id_jump  in  1 each  control bits.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_rd1, ex_rd2, ex_imm  out  DATA_WIDTH  registered copies of the id_* data.
- ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_alu_op, ex_alu_src, ex_wb_sel  out  (widths as id_*)  registered copies.
- ex_reg_we, ex_mem_re, ex_mem_we, ex_branch, ex_jump  out  1 each  registered copies.
- hazard_stall  out  1  load-use stall request to the PC and IF/ID registers.
- bubble_cnt  out  CNT_WIDTH  count of bubbles inserted.

Behaviour:
- Reset (async, while rst=1): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0. hazard_stall reads 0, because it depends on ex_valid.
- hazard_stall (combinational from registered EX state and current id_* inputs): asserted when all of the following hold:
  - ex_valid = 1 and ex_mem_re = 1;
  - ex_rd != 0;
  - id_valid = 1;
  - ex_rd == id_rs1 or ex_rd == id_rs2.
- hazard_stall is not gated by stall or flush. Upstream combines it itself.
- Per posedge, evaluate in priority order:
  1. flush = 1: load a bubble. Takes precedence over stall and hazard.
  2. stall = 1: hold all ex_* outputs unchanged; bubble_cnt unchanged.
  3. hazard_stall = 1: load a bubble; bubble_cnt increments.
  4. Otherwise: load all id_* into ex_*; ex_valid <= id_valid.
- Bubble: ex_valid and every ex_* field (data and control) load 0. EX sees a NOP with no side effects.
- A flush bubble does not increment bubble_cnt. Only hazard bubbles count.
- bubble_cnt saturates at all-ones; it never wraps.
- Latency: an id_* value appears on ex_* exactly one cycle after the capturing edge. There is no combinational path from id_* to ex_*.
- id_valid = 0 with no stall/flush/hazard: fields load as presented, ex_valid = 0. Downstream must qualify all side effects with ex_valid.
- Register-file write on the falling edge gives write-before-read in the same cycle. This block therefore needs no WB bypass; it captures id_rd1/id_rd2 as given.
- Hazard persistence: after a hazard bubble, ex_mem_re = 0, so hazard_stall drops the next cycle and the held instruction advances. The stall lasts exactly one cycle.
- rst asserted mid-operation clears state immediately, with no clock edge needed. Deassertion takes effect at the next posedge.

Test Plan:
- Reset, then normal load: rst pulse, then id_valid=1, id_pc=0x100, id_rd1=0xA5A5A5A5, id_rd=5, id_reg_we=1 -> next cycle ex_pc=0x100, ex_rd1=0xA5A5A5A5, ex_rd=5, ex_reg_we=1, ex_valid=1.
- Load-use: EX holds a load (ex_mem_re=1, ex_rd=3, ex_valid=1); ID presents id_rs2=3, id_valid=1 -> hazard_stall=1 that cycle. Next cycle all ex_*=0, bubble_cnt=1, hazard_stall=0. Following cycle the dependent instruction loads.
- rd = x0 exemption: same as the load-use case but ex_rd=0, id_rs1=0 -> hazard_stall=0; normal load; bubble_cnt unchanged.
- Stall hold: ex_pc=0x200; stall=1 for 3 cycles with changing id_* -> ex_* stays at 0x200 throughout, then captures the current id_* on the first edge after stall falls.
- Flush beats stall and hazard: flush=1, stall=1, hazard condition true -> next cycle ex_valid=0, all ex_* = 0, bubble_cnt unchanged.
- Async reset mid-stream and counter saturation:
  - Assert rst between edges -> ex_valid and ex_reg_we drop to 0 before the next posedge.
  - Separately, with CNT_WIDTH=4, force 20 hazards -> bubble_cnt stops at 15.
